// File: rtl/hazard_if.sv
// Pipeline-control bundle between the 5-stage core and hazard_ctrl.
// The core side uses the master modport and the hazard unit uses the slave modport.
interface hazard_if #(
    parameter int unsigned REG_ID_W = 5
);
    // Register ids and control bits sampled from the pipeline stages
    logic [REG_ID_W-1:0] rs_d;
    logic [REG_ID_W-1:0] rt_d;
    logic                branch_d;
    logic                pc_src_d;
    logic [REG_ID_W-1:0] rs_e;
    logic [REG_ID_W-1:0] rt_e;
    logic [REG_ID_W-1:0] write_reg_e;
    logic                reg_write_e;
    logic                mem_to_reg_e;
    logic [REG_ID_W-1:0] write_reg_m;
    logic                reg_write_m;
    logic                mem_to_reg_m;
    logic                mem_access_m;
    logic [REG_ID_W-1:0] write_reg_w;
    logic                reg_write_w;

    // Stall, flush and forward controls returned to the pipeline
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       flush_e_n;
    logic       bubble_w;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       forward_a_d;
    logic       forward_b_d;

    modport master (
        output rs_d, rt_d, branch_d, pc_src_d,
        output rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e,
        output write_reg_m, reg_write_m, mem_to_reg_m, mem_access_m,
        output write_reg_w, reg_write_w,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_e_n, bubble_w,
        input  forward_a_e, forward_b_e, forward_a_d, forward_b_d
    );

    modport slave (
        input  rs_d, rt_d, branch_d, pc_src_d,
        input  rs_e, rt_e, write_reg_e, reg_write_e, mem_to_reg_e,
        input  write_reg_m, reg_write_m, mem_to_reg_m, mem_access_m,
        input  write_reg_w, reg_write_w,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_e_n, bubble_w,
        output forward_a_e, forward_b_e, forward_a_d, forward_b_d
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core.
// Produces E/D forward selects, load-use and branch stalls, branch-redirect
// flushes, and a memory-wait FSM that freezes the pipeline for MEM_LAT extra
// cycles while a load/store sits in M.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_count counters.
module hazard_ctrl #(
    parameter int unsigned REG_ID_W = 5,
    parameter int unsigned MEM_LAT  = 0,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    hazard_if.slave           hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
`endif
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    // Counter load value on entering WAIT; unused when MEM_LAT is 0
    localparam logic [CNT_W-1:0] LatM1 = (MEM_LAT != 0) ? CNT_W'(MEM_LAT - 1) : '0;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall;
    logic             lw_stall;
    logic             br_stall;

    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, bubble_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d;

    // Register 0 is hard-wired zero, so it never creates a dependency
    function automatic logic id_hit(input logic [REG_ID_W-1:0] a,
                                    input logic [REG_ID_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Memory-wait FSM next state; an access completes on the cycle cnt hits zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        if (MEM_LAT != 0) begin
            if (state_q == StIdle) begin
                if (hz.mem_access_m) begin
                    mem_stall = 1'b1;
                    state_d   = StWait;
                    cnt_d     = LatM1;
                end
            end else begin
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end
        end
    end

    // Memory-wait FSM state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data-hazard detection on D-stage sources
    always_comb begin
        lw_stall = hz.mem_to_reg_e &&
                   (id_hit(hz.write_reg_e, hz.rs_d) || id_hit(hz.write_reg_e, hz.rt_d));
        br_stall = hz.branch_d &&
                   ((hz.reg_write_e &&
                     (id_hit(hz.write_reg_e, hz.rs_d) || id_hit(hz.write_reg_e, hz.rt_d))) ||
                    (hz.mem_to_reg_m &&
                     (id_hit(hz.write_reg_m, hz.rs_d) || id_hit(hz.write_reg_m, hz.rt_d))));
    end

    // Prioritised stall/flush/forward outputs; reset forces a clean pipeline
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        fwd_a_e  = 2'b00;
        fwd_b_e  = 2'b00;
        fwd_a_d  = 1'b0;
        fwd_b_d  = 1'b0;
        if (reset) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            bubble_w = 1'b1;
        end else begin
            // M result is newer than W, so it takes priority
            if (hz.reg_write_m && id_hit(hz.write_reg_m, hz.rs_e)) begin
                fwd_a_e = 2'b10;
            end else if (hz.reg_write_w && id_hit(hz.write_reg_w, hz.rs_e)) begin
                fwd_a_e = 2'b01;
            end
            if (hz.reg_write_m && id_hit(hz.write_reg_m, hz.rt_e)) begin
                fwd_b_e = 2'b10;
            end else if (hz.reg_write_w && id_hit(hz.write_reg_w, hz.rt_e)) begin
                fwd_b_e = 2'b01;
            end
            fwd_a_d = hz.reg_write_m && id_hit(hz.write_reg_m, hz.rs_d);
            fwd_b_d = hz.reg_write_m && id_hit(hz.write_reg_m, hz.rt_d);

            if (mem_stall) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                stall_m  = 1'b1;
                bubble_w = 1'b1;
            end else if (lw_stall || br_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (hz.pc_src_d) begin
                flush_d = 1'b1;
            end
        end
    end

    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.stall_e     = stall_e;
    assign hz.stall_m     = stall_m;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.flush_e_n   = ~flush_e;
    assign hz.bubble_w    = bubble_w;
    assign hz.forward_a_e = fwd_a_e;
    assign hz.forward_b_e = fwd_b_e;
    assign hz.forward_a_d = fwd_a_d;
    assign hz.forward_b_d = fwd_b_d;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;

    // Free-running wrap-around performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_f) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
            if (flush_d || flush_e) begin
                flush_count_q <= flush_count_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one DUT with MEM_LAT=0 and one with MEM_LAT=3.
// Control outputs are packed as {stall_f, stall_d, stall_e, stall_m,
// flush_d, flush_e, flush_e_n, bubble_w}.
module tb_hazard_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    hazard_if #(.REG_ID_W(5)) hz0 ();
    hazard_if #(.REG_ID_W(5)) hz3 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc0, fc0, sc3, fc3;
`endif

    hazard_ctrl #(.REG_ID_W(5), .MEM_LAT(0), .CNT_W(4), .PERF_W(32)) u_dut0 (
        .clock        (clock),
        .reset        (reset),
        .hz           (hz0)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (sc0),
        .flush_count  (fc0)
`endif
    );

    hazard_ctrl #(.REG_ID_W(5), .MEM_LAT(3), .CNT_W(4), .PERF_W(32)) u_dut3 (
        .clock        (clock),
        .reset        (reset),
        .hz           (hz3)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (sc3),
        .flush_count  (fc3)
`endif
    );

    logic [7:0] ctl0, ctl3;
    logic [5:0] fwd0;
    assign ctl0 = {hz0.stall_f, hz0.stall_d, hz0.stall_e, hz0.stall_m,
                   hz0.flush_d, hz0.flush_e, hz0.flush_e_n, hz0.bubble_w};
    assign ctl3 = {hz3.stall_f, hz3.stall_d, hz3.stall_e, hz3.stall_m,
                   hz3.flush_d, hz3.flush_e, hz3.flush_e_n, hz3.bubble_w};
    assign fwd0 = {hz0.forward_a_e, hz0.forward_b_e, hz0.forward_a_d, hz0.forward_b_d};

    localparam logic [7:0] CtlIdle  = 8'b0000_0010;
    localparam logic [7:0] CtlReset = 8'b0000_1101;
    localparam logic [7:0] CtlHaz   = 8'b1100_0100;
    localparam logic [7:0] CtlRedir = 8'b0000_1010;
    localparam logic [7:0] CtlMem   = 8'b1111_0011;

    task automatic clear_inputs();
        hz0.rs_d = '0; hz0.rt_d = '0; hz0.branch_d = 0; hz0.pc_src_d = 0;
        hz0.rs_e = '0; hz0.rt_e = '0; hz0.write_reg_e = '0;
        hz0.reg_write_e = 0; hz0.mem_to_reg_e = 0;
        hz0.write_reg_m = '0; hz0.reg_write_m = 0; hz0.mem_to_reg_m = 0;
        hz0.mem_access_m = 0; hz0.write_reg_w = '0; hz0.reg_write_w = 0;
        hz3.rs_d = '0; hz3.rt_d = '0; hz3.branch_d = 0; hz3.pc_src_d = 0;
        hz3.rs_e = '0; hz3.rt_e = '0; hz3.write_reg_e = '0;
        hz3.reg_write_e = 0; hz3.mem_to_reg_e = 0;
        hz3.write_reg_m = '0; hz3.reg_write_m = 0; hz3.mem_to_reg_m = 0;
        hz3.mem_access_m = 0; hz3.write_reg_w = '0; hz3.reg_write_w = 0;
    endtask

    // Move to 1 ns after the next rising edge, where new inputs are applied
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        hz0.rs_e = 5'd3; hz0.write_reg_m = 5'd3; hz0.reg_write_m = 1'b1;
        next_cycle();
        #1;
        n_cmp++;
        if (ctl0 !== CtlReset) begin
            n_bad++; $display("FAIL reset_ctl0: got %b want %b", ctl0, CtlReset);
        end
        n_cmp++;
        if (ctl3 !== CtlReset) begin
            n_bad++; $display("FAIL reset_ctl3: got %b want %b", ctl3, CtlReset);
        end
        n_cmp++;
        if (fwd0 !== 6'b0) begin
            n_bad++; $display("FAIL reset_fwd: got %b want %b", fwd0, 6'b0);
        end
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl0 !== CtlIdle) begin
            n_bad++; $display("FAIL post_reset_ctl0: got %b want %b", ctl0, CtlIdle);
        end
    endtask

    task automatic test_forward();
        next_cycle();
        clear_inputs();
        hz0.rs_e = 5'd3; hz0.rt_e = 5'd4;
        hz0.reg_write_m = 1'b1; hz0.write_reg_m = 5'd3;
        hz0.reg_write_w = 1'b1; hz0.write_reg_w = 5'd3;
        #1;
        n_cmp++;
        if (fwd0 !== 6'b10_00_0_0) begin
            n_bad++; $display("FAIL fwd_m_prio: got %b want %b", fwd0, 6'b10_00_0_0);
        end
        hz0.reg_write_m = 1'b0;
        #1;
        n_cmp++;
        if (fwd0 !== 6'b01_00_0_0) begin
            n_bad++; $display("FAIL fwd_w: got %b want %b", fwd0, 6'b01_00_0_0);
        end
        hz0.rs_e = 5'd0; hz0.reg_write_m = 1'b1; hz0.write_reg_m = 5'd0; hz0.write_reg_w = 5'd0;
        #1;
        n_cmp++;
        if (fwd0 !== 6'b00_00_0_0) begin
            n_bad++; $display("FAIL fwd_reg0: got %b want %b", fwd0, 6'b00_00_0_0);
        end
        hz0.rs_e = 5'd9; hz0.rt_e = 5'd9; hz0.write_reg_m = 5'd9; hz0.write_reg_w = 5'd9;
        #1;
        n_cmp++;
        if (fwd0 !== 6'b10_10_0_0) begin
            n_bad++; $display("FAIL fwd_both_m: got %b want %b", fwd0, 6'b10_10_0_0);
        end
        hz0.rs_e = 5'd0; hz0.rt_e = 5'd12; hz0.write_reg_w = 5'd12;
        hz0.rs_d = 5'd9; hz0.rt_d = 5'd2;
        #1;
        n_cmp++;
        if (fwd0 !== 6'b00_01_1_0) begin
            n_bad++; $display("FAIL fwd_d_a: got %b want %b", fwd0, 6'b00_01_1_0);
        end
        hz0.rs_d = 5'd2; hz0.rt_d = 5'd9;
        #1;
        n_cmp++;
        if (fwd0 !== 6'b00_01_0_1) begin
            n_bad++; $display("FAIL fwd_d_b: got %b want %b", fwd0, 6'b00_01_0_1);
        end
        n_cmp++;
        if (ctl0 !== CtlIdle) begin
            n_bad++; $display("FAIL fwd_no_stall: got %b want %b", ctl0, CtlIdle);
        end
    endtask

    task automatic test_lw_stall();
        next_cycle();
        clear_inputs();
        hz0.mem_to_reg_e = 1'b1; hz0.write_reg_e = 5'd5; hz0.rt_d = 5'd5;
        #1;
        n_cmp++;
        if (ctl0 !== CtlHaz) begin
            n_bad++; $display("FAIL lw_stall: got %b want %b", ctl0, CtlHaz);
        end
        next_cycle();
        hz0.mem_to_reg_e = 1'b0; hz0.write_reg_e = 5'd0;
        #1;
        n_cmp++;
        if (ctl0 !== CtlIdle) begin
            n_bad++; $display("FAIL lw_release: got %b want %b", ctl0, CtlIdle);
        end
        hz0.mem_to_reg_e = 1'b1; hz0.rt_d = 5'd0;
        #1;
        n_cmp++;
        if (ctl0 !== CtlIdle) begin
            n_bad++; $display("FAIL lw_reg0: got %b want %b", ctl0, CtlIdle);
        end
    endtask

    task automatic test_branch();
        next_cycle();
        clear_inputs();
        hz0.branch_d = 1'b1; hz0.rs_d = 5'd7; hz0.pc_src_d = 1'b1;
        hz0.reg_write_e = 1'b1; hz0.write_reg_e = 5'd7;
        #1;
        n_cmp++;
        if (ctl0 !== CtlHaz) begin
            n_bad++; $display("FAIL br_stall_e: got %b want %b", ctl0, CtlHaz);
        end
        next_cycle();
        hz0.reg_write_e = 1'b0;
        #1;
        n_cmp++;
        if (ctl0 !== CtlRedir) begin
            n_bad++; $display("FAIL br_redirect: got %b want %b", ctl0, CtlRedir);
        end
        hz0.mem_to_reg_m = 1'b1; hz0.write_reg_m = 5'd7;
        #1;
        n_cmp++;
        if (ctl0 !== CtlHaz) begin
            n_bad++; $display("FAIL br_stall_m: got %b want %b", ctl0, CtlHaz);
        end
    endtask

    task automatic test_mem_wait();
        logic [7:0] exp_seq [8];
        exp_seq = '{CtlMem, CtlMem, CtlMem, CtlRedir, CtlMem, CtlMem, CtlMem, CtlRedir};
        next_cycle();
        clear_inputs();
        hz3.mem_access_m = 1'b1; hz3.pc_src_d = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) next_cycle();
            #1;
            n_cmp++;
            if (ctl3 !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL mem_wait_cyc%0d: got %b want %b", i + 1, ctl3, exp_seq[i]);
            end
        end
        hz3.mem_access_m = 1'b0; hz3.pc_src_d = 1'b0;
        // Stall must dominate a simultaneous load-use hazard, which resurfaces after release
        next_cycle();
        hz3.mem_access_m = 1'b1;
        hz3.mem_to_reg_e = 1'b1; hz3.write_reg_e = 5'd5; hz3.rs_d = 5'd5;
        #1;
        n_cmp++;
        if (ctl3 !== CtlMem) begin
            n_bad++; $display("FAIL mem_over_lw: got %b want %b", ctl3, CtlMem);
        end
        next_cycle(); next_cycle(); next_cycle();
        #1;
        n_cmp++;
        if (ctl3 !== CtlHaz) begin
            n_bad++; $display("FAIL lw_after_mem: got %b want %b", ctl3, CtlHaz);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        clear_inputs();
        hz3.mem_access_m = 1'b1;
        #1;
        n_cmp++;
        if (hz3.stall_m !== 1'b1) begin
            n_bad++; $display("FAIL rst_wait_cyc1: got %b want %b", hz3.stall_m, 1'b1);
        end
        next_cycle();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ctl3 !== CtlReset) begin
            n_bad++; $display("FAIL rst_wait_forced: got %b want %b", ctl3, CtlReset);
        end
        next_cycle();
        reset = 1'b0;
        hz3.mem_access_m = 1'b0;
        #1;
        n_cmp++;
        if (hz3.stall_m !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_abort: got %b want %b", hz3.stall_m, 1'b0);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (ctl3 !== CtlIdle) begin
            n_bad++; $display("FAIL rst_wait_idle: got %b want %b", ctl3, CtlIdle);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        hz3.mem_to_reg_e = 1'b1; hz3.write_reg_e = 5'd5; hz3.rt_d = 5'd5;
        next_cycle();
        clear_inputs();
        hz3.mem_access_m = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        hz3.mem_access_m = 1'b0;
        next_cycle();
        n_cmp++;
        if (sc3 !== 32'd4) begin
            n_bad++; $display("FAIL perf_stall_cycles: got %0d want %0d", sc3, 4);
        end
        n_cmp++;
        if (fc3 !== 32'd1) begin
            n_bad++; $display("FAIL perf_flush_count: got %0d want %0d", fc3, 1);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_forward();
        test_lw_stall();
        test_branch();
        test_mem_wait();
        test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
